// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding word reads,
// buffers returned words in a small FIFO and hands {instr, instr_pc} to the controller.
module fetch_unit #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr,
  output logic [15:0] instr_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  typedef struct packed {
    logic [15:0] word;
    logic [15:0] pc;
  } entry_t;

  state_t          state;
  logic [15:0]     fetch_pc;
  entry_t          fifo [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;

  logic            push, pop, can_issue;
  logic [CW-1:0]   count_next, count_kept;
  logic [AW-1:0]   rd_next, wr_next;
  entry_t          push_entry, head_next;
  logic [15:0]     discard_pc;

  // Redirect voids both a same-cycle push and a same-cycle pop.
  always_comb begin
    push       = (state == WAIT) && mem_ack && !redirect_en;
    pop        = instr_valid && instr_ready && !redirect_en;
    push_entry = '{word: mem_rdata, pc: mem_addr};
    count_kept = count - CW'(pop);
    count_next = redirect_en ? '0 : count_kept + CW'(push);
    rd_next    = redirect_en ? '0 : rd_ptr + AW'(pop);
    wr_next    = redirect_en ? '0 : wr_ptr + AW'(push);
    can_issue  = count_next < CW'(DEPTH);
    // When nothing older survives the pop, the word arriving now becomes the head.
    head_next  = (count_kept == '0) ? push_entry : fifo[rd_next];
    discard_pc = redirect_en ? redirect_pc : fetch_pc;
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      mem_req     <= 1'b0;
      mem_addr    <= RESET_PC;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      count       <= count_next;
      rd_ptr      <= rd_next;
      wr_ptr      <= wr_next;
      instr_valid <= (count_next != '0);
      if (count_next != '0) begin
        instr    <= head_next.word;
        instr_pc <= head_next.pc;
      end
      case (state)
        IDLE: begin
          if (redirect_en) begin
            fetch_pc <= redirect_pc;
            mem_req  <= 1'b1;
            mem_addr <= redirect_pc;
            state    <= WAIT;
          end else if (can_issue) begin
            mem_req  <= 1'b1;
            mem_addr <= fetch_pc;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (redirect_en) begin
            fetch_pc <= redirect_pc;
            if (mem_ack) mem_addr <= redirect_pc;
            else         state    <= DISCARD;
          end else if (mem_ack) begin
            fetch_pc <= fetch_pc + 16'd1;
            if (can_issue) begin
              mem_addr <= fetch_pc + 16'd1;
            end else begin
              mem_req <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        DISCARD: begin
          // Stale read still on the bus: keep the request stable until it completes.
          if (redirect_en) fetch_pc <= redirect_pc;
          if (mem_ack) begin
            mem_addr <= discard_pc;
            state    <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory returns addr^16'hA000, expectations hand-computed.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        redirect_en = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr;
  logic [15:0] instr_pc;

  logic ack_tie = 1'b0;
  logic ack_man = 1'b0;

  int errors = 0;
  int checks = 0;

  assign mem_ack   = ack_tie | ack_man;
  assign mem_rdata = mem_addr ^ 16'hA000;

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(2), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    // Reset state
    #2 rst = 1'b0;
    #2;
    chk("rst_req",   {31'b0, mem_req}, 32'd0);
    chk("rst_addr",  {16'b0, mem_addr}, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", {16'b0, instr}, 32'h0);
    chk("rst_pc",    {16'b0, instr_pc}, 32'h0);

    // 1: streaming, zero-wait ack, always ready
    ack_tie = 1'b1; instr_ready = 1'b1;
    @(negedge clk); rst = 1'b1;
    step();
    chk("t1_req0",   {31'b0, mem_req}, 32'd1);
    chk("t1_addr0",  {16'b0, mem_addr}, 32'h0);
    chk("t1_val0",   {31'b0, instr_valid}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t1_valid", {31'b0, instr_valid}, 32'd1);
      chk("t1_instr", {16'b0, instr}, 32'(16'hA000 + 16'(k)));
      chk("t1_pc",    {16'b0, instr_pc}, 32'(k));
      chk("t1_addr",  {16'b0, mem_addr}, 32'(k + 1));
    end

    // 2: consumer stalled, FIFO fills to DEPTH then fetch stops
    instr_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 6; k++) step();
    chk("t2_req_off", {31'b0, mem_req}, 32'd0);
    chk("t2_valid",   {31'b0, instr_valid}, 32'd1);
    chk("t2_head",    {16'b0, instr}, 32'h0000A000);
    chk("t2_head_pc", {16'b0, instr_pc}, 32'h0);
    instr_ready = 1'b1;
    step();
    chk("t2_pc1",     {16'b0, instr_pc}, 32'h1);
    chk("t2_instr1",  {16'b0, instr}, 32'h0000A001);
    chk("t2_req_on",  {31'b0, mem_req}, 32'd1);
    chk("t2_resume",  {16'b0, mem_addr}, 32'h2);
    step();
    chk("t2_pc2",     {16'b0, instr_pc}, 32'h2);
    chk("t2_instr2",  {16'b0, instr}, 32'h0000A002);

    // 3: delayed ack at addr 5 with redirect while outstanding
    ack_tie = 1'b0; ack_man = 1'b0;
    do_reset();
    redirect_en = 1'b1; redirect_pc = 16'h0005;
    step();
    chk("t3_addr5",   {16'b0, mem_addr}, 32'h5);
    redirect_pc = 16'h0040;
    step();
    redirect_en = 1'b0;
    chk("t3_hold1",   {16'b0, mem_addr}, 32'h5);
    chk("t3_req1",    {31'b0, mem_req}, 32'd1);
    step();
    chk("t3_hold2",   {16'b0, mem_addr}, 32'h5);
    ack_man = 1'b1;
    step();
    ack_man = 1'b0;
    chk("t3_newaddr", {16'b0, mem_addr}, 32'h40);
    chk("t3_noval",   {31'b0, instr_valid}, 32'd0);
    ack_tie = 1'b1;
    step();
    chk("t3_valid",   {31'b0, instr_valid}, 32'd1);
    chk("t3_pc",      {16'b0, instr_pc}, 32'h40);
    chk("t3_instr",   {16'b0, instr}, 32'h0000A040);

    // 4: redirect coincident with ack and pop
    instr_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) step();
    instr_ready = 1'b1;
    step();
    chk("t4_pre_pc",  {16'b0, instr_pc}, 32'h1);
    chk("t4_pre_addr",{16'b0, mem_addr}, 32'h2);
    redirect_en = 1'b1; redirect_pc = 16'h0080;
    step();
    redirect_en = 1'b0;
    chk("t4_flush",   {31'b0, instr_valid}, 32'd0);
    chk("t4_req",     {31'b0, mem_req}, 32'd1);
    chk("t4_addr",    {16'b0, mem_addr}, 32'h80);
    step();
    chk("t4_pc",      {16'b0, instr_pc}, 32'h80);
    chk("t4_instr",   {16'b0, instr}, 32'h0000A080);

    // 5: PC wrap FFFF -> 0000
    redirect_en = 1'b1; redirect_pc = 16'hFFFF;
    step();
    redirect_en = 1'b0;
    chk("t5_addr",    {16'b0, mem_addr}, 32'hFFFF);
    step();
    chk("t5_pcF",     {16'b0, instr_pc}, 32'hFFFF);
    chk("t5_instrF",  {16'b0, instr}, 32'h00005FFF);
    chk("t5_wrap",    {16'b0, mem_addr}, 32'h0);
    step();
    chk("t5_pc0",     {16'b0, instr_pc}, 32'h0);
    chk("t5_instr0",  {16'b0, instr}, 32'h0000A000);

    // 6: async reset mid-WAIT with one word buffered
    instr_ready = 1'b0; ack_tie = 1'b0;
    step();
    chk("t6_pre_val", {31'b0, instr_valid}, 32'd1);
    chk("t6_pre_req", {31'b0, mem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t6_req",     {31'b0, mem_req}, 32'd0);
    chk("t6_valid",   {31'b0, instr_valid}, 32'd0);
    chk("t6_addr",    {16'b0, mem_addr}, 32'h0);
    rst = 1'b1; ack_tie = 1'b1; instr_ready = 1'b1;
    step();
    chk("t6_refetch", {16'b0, mem_addr}, 32'h0);
    chk("t6_req_on",  {31'b0, mem_req}, 32'd1);
    step();
    chk("t6_pc",      {16'b0, instr_pc}, 32'h0);
    chk("t6_instr",   {16'b0, instr}, 32'h0000A000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
